// File: rtl/acc_fifo.sv
// acc_fifo: single-clock FIFO between the router and one accelerator.
// Registered data_out, full, empty and count. Sticky overflow and underflow
// flags latch handshake violations until reset or flush.
module acc_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,      // asynchronous, active-low
   input  logic             flush,
   input  logic             put_req,
   input  logic [WIDTH-1:0] data_in,
   input  logic             get_req,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   // Storage array. It has no reset because flush and reset leave the
   // contents undefined.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic [WIDTH-1:0] dout_q, dout_d;

   logic             put_acc;
   logic             get_acc;
   logic             wr_en;

   // Accept decisions use only the registered flags. The requests never
   // reach the flags combinationally.
   always_comb begin
      put_acc = put_req & ~full_q;
      get_acc = get_req & ~empty_q;
      // A flush cycle ignores both requests, so it blocks the array write.
      wr_en   = put_acc & ~flush;
   end

   // Next-state logic for the pointers, occupancy, flags and read data.
   always_comb begin
      wp_d        = wp_q;
      rp_d        = rp_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      dout_d      = dout_q;

      if (flush) begin
         // Clear everything except data_out, which keeps the last word read.
         wp_d        = '0;
         rp_d        = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (put_acc) begin
            wp_d = wp_q + PTR_ONE;
         end
         if (get_acc) begin
            rp_d   = rp_q + PTR_ONE;
            dout_d = mem[rp_q];
         end
         case ({put_acc, get_acc})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
         endcase
         // Any rejected request is a handshake violation. The flag stays
         // set until it is cleared.
         if (put_req && full_q) begin
            overflow_d = 1'b1;
         end
         if (get_req && empty_q) begin
            underflow_d = 1'b1;
         end
      end

      full_d  = (count_d == COUNT_FULL);
      empty_d = (count_d == '0);
   end

   // Control and output registers, with an asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp_q        <= '0;
         rp_q        <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         dout_q      <= dout_d;
      end
   end

   // Array write port. Only accepted puts outside a flush cycle write the array.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wp_q] <= data_in;
      end
   end

   // Drive the outputs from the registers.
   always_comb begin
      data_out  = dout_q;
      full      = full_q;
      empty     = empty_q;
      count     = count_q;
      overflow  = overflow_q;
      underflow = underflow_q;
   end

endmodule

// File: tb/tb_acc_fifo.sv
// Directed testbench for acc_fifo. It runs a fixed sequence of steps and
// checks each result with an immediate assertion against a hand-computed value.
module tb_acc_fifo;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        put_req;
   logic [31:0] data_in;
   logic        get_req;
   logic [31:0] data_out;
   logic        full;
   logic        empty;
   logic [4:0]  count;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   acc_fifo #(.WIDTH(32), .DEPTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .put_req   (put_req),
      .data_in   (data_in),
      .get_req   (get_req),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and record the result.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, let one rising edge pass, then return
   // the inputs to idle 1 time unit after that edge.
   task automatic step(input logic p, input logic [31:0] d, input logic g, input logic f);
      put_req = p;
      data_in = d;
      get_req = g;
      flush   = f;
      @(posedge clk);
      #1;
      put_req = 1'b0;
      get_req = 1'b0;
      flush   = 1'b0;
   endtask

   // Check that every output holds its reset value.
   task automatic chk_reset_state(input string tag);
      chk({tag, ".empty"},     32'(empty),     32'd1);
      chk({tag, ".full"},      32'(full),      32'd0);
      chk({tag, ".count"},     32'(count),     32'd0);
      chk({tag, ".data_out"},  data_out,       32'd0);
      chk({tag, ".overflow"},  32'(overflow),  32'd0);
      chk({tag, ".underflow"}, 32'(underflow), 32'd0);
   endtask

   // Stop the run if the sequence never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset   = 1'b0;
      flush   = 1'b0;
      put_req = 1'b0;
      get_req = 1'b0;
      data_in = '0;

      // Hold reset for 5 cycles. The outputs must stay at reset values throughout.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk_reset_state("reset_hold");
      end
      reset = 1'b1;

      // Fill with 1..16 and check the count after each put.
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 32'(i), 1'b0, 1'b0);
         chk("fill.count", 32'(count), 32'(i));
      end
      chk("fill.full", 32'(full), 32'd1);
      chk("fill.empty", 32'(empty), 32'd0);

      // A put while full is rejected and sets the overflow flag.
      step(1'b1, 32'd99, 1'b0, 1'b0);
      chk("ovf.flag", 32'(overflow), 32'd1);
      chk("ovf.count", 32'(count), 32'd16);
      chk("ovf.full", 32'(full), 32'd1);

      // Drain: data_out must read 1..16 in order. The rejected 99 must not appear.
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         chk("drain.data", data_out, 32'(i));
         chk("drain.count", 32'(count), 32'(16 - i));
      end
      chk("drain.empty", 32'(empty), 32'd1);
      chk("drain.full", 32'(full), 32'd0);

      // A get while empty sets underflow. data_out must hold its last value.
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("unf.flag", 32'(underflow), 32'd1);
      chk("unf.data_hold", data_out, 32'd16);
      chk("unf.count", 32'(count), 32'd0);
      chk("unf.ovf_sticky", 32'(overflow), 32'd1);

      // Flush clears the sticky flags.
      step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("flush1.ovf", 32'(overflow), 32'd0);
      chk("flush1.unf", 32'(underflow), 32'd0);
      chk("flush1.data", data_out, 32'd16);

      // Put and get together at count=5: the count stays 5 and order is kept.
      for (int i = 0; i < 5; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
      chk("sim5.count_pre", 32'(count), 32'd5);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 32'(200 + k), 1'b1, 1'b0);
         chk("sim5.data", data_out, (k < 5) ? 32'(100 + k) : 32'(200 + k - 5));
         chk("sim5.count", 32'(count), 32'd5);
      end
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         chk("sim5.tail", data_out, 32'(205 + k));
      end
      chk("sim5.empty", 32'(empty), 32'd1);

      // Put and get together while empty: only the put is accepted (no fall-through).
      step(1'b1, 32'd7, 1'b1, 1'b0);
      chk("simE.count", 32'(count), 32'd1);
      chk("simE.unf", 32'(underflow), 32'd1);
      chk("simE.empty", 32'(empty), 32'd0);
      chk("simE.data_hold", data_out, 32'd209);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("simE.read7", data_out, 32'd7);
      chk("simE.empty_after", 32'(empty), 32'd1);
      step(1'b0, 32'd0, 1'b0, 1'b1);

      // Put and get together while full: only the get is accepted.
      for (int i = 0; i < 16; i++) step(1'b1, 32'(300 + i), 1'b0, 1'b0);
      chk("simF.full_pre", 32'(full), 32'd1);
      step(1'b1, 32'd500, 1'b1, 1'b0);
      chk("simF.count", 32'(count), 32'd15);
      chk("simF.ovf", 32'(overflow), 32'd1);
      chk("simF.data", data_out, 32'd300);
      chk("simF.full", 32'(full), 32'd0);
      step(1'b0, 32'd0, 1'b0, 1'b1);

      // Pointer wrap: 40 put/get pairs at a steady count of 3.
      for (int i = 0; i < 3; i++) step(1'b1, 32'(1000 + i), 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 32'(k), 1'b1, 1'b0);
         chk("wrap.data", data_out, (k < 3) ? 32'(1000 + k) : 32'(k - 3));
         chk("wrap.count", 32'(count), 32'd3);
         chk("wrap.full", 32'(full), 32'd0);
         chk("wrap.empty", 32'(empty), 32'd0);
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         chk("wrap.tail", data_out, 32'(37 + k));
      end

      // Flush at count=9 with put_req asserted: the put is ignored.
      for (int i = 0; i < 9; i++) step(1'b1, 32'(600 + i), 1'b0, 1'b0);
      chk("flush9.count_pre", 32'(count), 32'd9);
      step(1'b1, 32'd777, 1'b0, 1'b1);
      chk("flush9.count", 32'(count), 32'd0);
      chk("flush9.empty", 32'(empty), 32'd1);
      chk("flush9.full", 32'(full), 32'd0);
      chk("flush9.ovf", 32'(overflow), 32'd0);
      chk("flush9.unf", 32'(underflow), 32'd0);
      chk("flush9.data", data_out, 32'd39);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("flush9.no_put", 32'(underflow), 32'd1);
      chk("flush9.data_hold", data_out, 32'd39);

      // Pulse the asynchronous reset low between edges. The outputs must
      // return to reset values before the next edge.
      for (int i = 0; i < 4; i++) step(1'b1, 32'(800 + i), 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("areset.pre_data", data_out, 32'd800);
      #4;
      reset = 1'b0;
      #1;
      chk_reset_state("areset.immediate");
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk_reset_state("areset.held");

      // The FIFO must be usable right after reset is released.
      step(1'b1, 32'd42, 1'b0, 1'b0);
      chk("post_reset.count", 32'(count), 32'd1);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("post_reset.data", data_out, 32'd42);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
